mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit that sits directly downstream of the register
//  file's read ports (RData1 -> A, RData2 -> B). It executes MULT/MULTU/DIV/DIVU
//  into dedicated HI/LO registers over multiple cycles. It raises busy so the
//  single-cycle datapath stalls PC/RegWrite until the result is ready.
//  HI/LO are read back by MFHI/MFLO through the writeback mux.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits
//  CNT_W   6    iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk     in   1      system clock, rising edge
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request: launch op using A/B, sampled in IDLE only
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  A       in   WIDTH  operand rs (multiplicand / dividend)
//  B       in   WIDTH  operand rt (multiplier / divisor)
//  mthi    in   1      write A into HI (MTHI)
//  mtlo    in   1      write A into LO (MTLO)
//  busy    out  1      op in progress; CPU stalls while high
//  done    out  1      one-cycle pulse: HI/LO just updated by an op
//  div0    out  1      sticky per-op flag: last DIV/DIVU had B==0
//  HI      out  WIDTH  product[63:32] / remainder
//  LO      out  WIDTH  product[31:0]  / quotient
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; HI=LO=0; busy=done=div0=0.
//   - Aborts any op in flight; no partial result reaches HI/LO.
//  States: IDLE -> RUN -> FIX -> IDLE.
//   - IDLE, start=1 at edge E0:
//     - latch |A|, |B| (signed ops) or raw A, B (unsigned ops).
//     - record result signs, clear accumulator and counter; go RUN.
//   - RUN: one shift-add (mul) or restoring shift-subtract (div) step per edge.
//     - exactly WIDTH iterations, edges E1..E32; then go FIX.
//   - FIX, edge E33: apply sign correction, register HI/LO, done=1; go IDLE.
//  Timing:
//   - busy=1 from E0 through the cycle before E33; busy=0 when done=1.
//   - Latency start->done is WIDTH+1 edges (33).
//   - done lasts exactly one cycle.
//   - A new start may be accepted in the cycle done is high (back-to-back).
//  Arithmetic:
//   - MULT/MULTU give the full 2*WIDTH product; MULT is two's complement.
//   - DIV truncates toward zero; remainder takes the sign of the dividend.
//   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
//   - B==0 on DIV/DIVU: LO=all ones, HI=A (raw), div0=1.
//     - Same 33-cycle latency; no early exit.
//   - div0 is cleared by the next accepted start.
//  Priority / conflicts:
//   - start while busy: ignored, operands not re-latched.
//   - mthi/mtlo honoured only in IDLE; ignored while busy.
//   - start with mthi/mtlo in the same IDLE cycle: start wins, mt* dropped.
//   - mthi and mtlo together: both HI and LO take A.
//  A/B may change after E0 without affecting the running op.
// TESTING
//  1 MULTU A=B=0xFFFFFFFF -> 33 edges later done=1, HI=0xFFFFFFFE, LO=0x00000001
//  2 MULT A=-3, B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy high exactly 33 cycles
//  3 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0
//  4 DIVU A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064, div0=1; next MULTU start clears div0
//  5 start MULTU 6*7, pulse start with A=B=9 at E10, rst_n=0 at E20 -> HI=LO=0, busy=0,
//    no done; repeat without reset -> LO=42 (second start ignored)
//  6 IDLE mtlo A=0x1234 -> LO=0x1234 next edge; mthi while busy -> HI unchanged

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-step multiply/divide unit with HI/LO result registers.
// A shift-add or restoring shift-subtract runs on operand magnitudes, and a final FIX cycle applies the signs.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_p_q, neg_p_d;
  logic               neg_r_q, neg_r_d;
  logic               bzero_q, bzero_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res;

  assign a_neg = ~op[0] & A[WIDTH-1];
  assign b_neg = ~op[0] & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // acc_hi carries the partial product (mul) or the partial remainder (div);
  // acc_lo shifts out multiplier bits (mul) or dividend bits (div).
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
  assign rem_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_ge   = rem_sh >= {1'b0, opd_q};
  assign rem_diff = rem_sh[WIDTH-1:0] - opd_q;

  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_res = neg_p_q ? -prod_mag : prod_mag;
  assign quo_res  = neg_p_q ? -acc_lo_q : acc_lo_q;
  assign rem_res  = neg_r_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    bzero_d  = bzero_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_hi_d = '0;
          is_div_d = op[1];
          neg_p_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          bzero_d  = op[1] && (B == '0);
          div0_d   = 1'b0;
          opd_d    = op[1] ? b_mag : a_mag;
          acc_lo_d = op[1] ? a_mag : b_mag;
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (is_div_q) begin
          acc_hi_d = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        div0_d  = bzero_q;
        if (is_div_q) begin
          // Divide by zero leaves the dividend in the remainder; only LO is forced.
          hi_d = rem_res;
          lo_d = bzero_q ? '1 : quo_res;
        end else begin
          hi_d = prod_res[2*WIDTH-1:WIDTH];
          lo_d = prod_res[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_p_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      bzero_q  <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_p_q  <= neg_p_d;
      neg_r_q  <= neg_r_d;
      bzero_q  <= bzero_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        busy, done, div0;
  logic [31:0] HI, LO;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_div0 = 1'b0;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .div0(div0),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: ops as plain 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic d0);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up, tmp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    d0 = 1'b0;
    case (o)
      2'b00: begin sp = sa * sb; tmp = sp; hi = tmp[63:32]; lo = tmp[31:0]; end
      2'b01: begin up = {32'b0, a} * {32'b0, b}; hi = up[63:32]; lo = up[31:0]; end
      2'b10: begin
        if (b == 0) begin hi = a; lo = '1; d0 = 1'b1; end
        else begin
          sq = sa / sb; sr = sa % sb;
          tmp = sq; lo = tmp[31:0];
          tmp = sr; hi = tmp[31:0];
        end
      end
      default: begin
        if (b == 0) begin hi = a; lo = '1; d0 = 1'b1; end
        else begin hi = a % b; lo = a / b; end
      end
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge where done is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int lat, bc;
    logic [31:0] hi_before, lo_before, ehi, elo;
    logic ed0;
    hi_before = '0;
    lo_before = '0;
    start = 1'b1; op = o; A = a; B = b;
    mthi = poke; mtlo = poke;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    A = $urandom; B = $urandom;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("div0_cleared_on_start", 32'(div0), 32'd0);
    chk("hi_kept_on_start", HI, m_hi);
    chk("lo_kept_on_start", LO, m_lo);
    lat = 0;
    bc = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (poke && lat == 9) begin start = 1'b1; A = 32'd9; B = 32'd9; end
      if (poke && lat == 14) begin mthi = 1'b1; mtlo = 1'b1; A = 32'hdead_beef; hi_before = HI; lo_before = LO; end
      @(negedge clk);
      lat++;
      if (busy) bc++;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (poke && lat == 15) begin
        chk("mthi_ignored_busy", HI, hi_before);
        chk("mtlo_ignored_busy", LO, lo_before);
      end
    end
    model(o, a, b, ehi, elo, ed0);
    m_hi = ehi; m_lo = elo; m_div0 = ed0;
    chk("latency", 32'(lat), 32'd33);
    chk("busy_cycles", 32'(bc), 32'd33);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
    chk("div0", 32'(div0), 32'(m_div0));
  endtask

  initial begin
    int sel;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(2'b01, 32'hffff_ffff, 32'hffff_ffff, 1'b0);
    chk("multu_max_hi", HI, 32'hffff_fffe);
    chk("multu_max_lo", LO, 32'h0000_0001);
    do_op(2'b00, -32'sd3, 32'd5, 1'b0);
    do_op(2'b10, -32'sd7, 32'd2, 1'b0);
    chk("div_neg_lo", LO, 32'hffff_fffd);
    chk("div_neg_hi", HI, 32'hffff_ffff);
    do_op(2'b10, 32'h8000_0000, 32'hffff_ffff, 1'b0);
    chk("div_ovf_lo", LO, 32'h8000_0000);
    chk("div_ovf_hi", HI, 32'h0000_0000);
    do_op(2'b11, 32'd100, 32'd0, 1'b0);
    chk("divu0_div0", 32'(div0), 32'd1);
    do_op(2'b00, 32'd4, 32'hffff_fffe, 1'b1);
    do_op(2'b10, -32'sd9, 32'd0, 1'b0);

    // IDLE moves into HI/LO
    mtlo = 1'b1; A = 32'h0000_1234;
    @(negedge clk);
    mtlo = 1'b0;
    m_lo = 32'h0000_1234;
    chk("mtlo_idle_lo", LO, m_lo);
    chk("mtlo_idle_hi", HI, m_hi);
    mthi = 1'b1; mtlo = 1'b1; A = 32'h5555_aaaa;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    m_hi = 32'h5555_aaaa; m_lo = 32'h5555_aaaa;
    chk("mt_both_hi", HI, m_hi);
    chk("mt_both_lo", LO, m_lo);

    // Reset mid-operation aborts with no done and no partial result.
    start = 1'b1; op = 2'b01; A = 32'd6; B = 32'd7;
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      start = (k == 8);
      if (k == 8) begin A = 32'd9; B = 32'd9; end
      if (k == 0) chk("abort_busy_running", 32'(busy), 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_HI", HI, 32'd0);
    chk("abort_LO", LO, 32'd0);
    m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op(2'b01, 32'd6, 32'd7, 1'b1);
    chk("ignored_restart_lo", LO, 32'd42);
    chk("ignored_restart_hi", HI, 32'd0);

    for (int i = 0; i < 16; i++) begin
      sel = $urandom_range(0, 5);
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) begin rb = 32'd0; end
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hffff_ffff; end
      else if (sel == 2) begin ra = 32'(-$urandom_range(1, 1000)); rb = 32'($urandom_range(1, 50)); end
      else if (sel == 3) begin rb = 32'($urandom_range(1, 7)); end
      do_op(ro, ra, rb, (i % 5) == 2);
    end

    @(negedge clk);
    chk("done_drops", 32'(done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
